// File: rtl/uncache_unit.sv
// rtl/uncache_unit.sv - uncached load/store bus sequencer for the MEM2 stage
// Optional posted-store write buffer enabled by defining UNCACHE_WBUF_EN.
module uncache_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, state_next;
    logic   access;
    logic   start;

    assign access  = valid & (rd | wr);
    assign bus_req = (state == REQ);

`ifdef UNCACHE_WBUF_EN
    logic wbuf_full;
    logic post;

    // A store seen in IDLE is posted: the bus registers double as the buffer.
    assign post = access & wr & ~rd;

    always_comb begin
        stall = 1'b0;
        if (rst)
            stall = 1'b0;
        else if (state == IDLE)
            stall = access & ~post;
        else if (wbuf_full)
            stall = access;
        else
            stall = access & (state != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wbuf_full <= 1'b0;
        else if (start)
            wbuf_full <= post;
        else if (state == DONE)
            wbuf_full <= 1'b0;
    end
`else
    assign stall = ~rst & access & (state != DONE);
`endif

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ:     if (bus_addr_ok) state_next = WAIT;
            WAIT:    if (bus_data_ok) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Request fields are latched once and held steady until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= 32'd0;
            bus_wstrb <= 4'd0;
            bus_wdata <= 32'd0;
        end else if (start) begin
            bus_wr    <= wr;
            bus_size  <= size;
            bus_addr  <= addr;
            bus_wstrb <= wstrb;
            bus_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= 32'd0;
        else if ((state == WAIT) && bus_data_ok && !bus_wr)
            rdata <= bus_rdata;
    end

endmodule

// File: tb/tb_uncache_unit.sv
// tb/tb_uncache_unit.sv - directed table-driven bench for uncache_unit
// Build with UNCACHE_WBUF_EN defined to exercise the posted-store path.
module tb_uncache_unit;

    logic        clk = 1'b0;
    logic        rst, valid, rd, wr;
    logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  wstrb, bus_wstrb;
    logic [1:0]  size, bus_size;
    logic        stall, bus_req, bus_wr, bus_addr_ok, bus_data_ok;

    int errors = 0;
    int checks = 0;

`ifdef UNCACHE_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    always #5 clk = ~clk;

    uncache_unit dut (
        .clk(clk), .rst(rst), .valid(valid), .rd(rd), .wr(wr), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .size(size), .stall(stall), .rdata(rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        r, v, rd, wr;
        logic [31:0] a;
        logic        aok, dok;
        logic [31:0] brd;
        logic        e_stall, e_req;
        logic [31:0] e_rdata, e_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, v, rd_, wr_, input logic [31:0] a,
                                input logic aok, dok, input logic [31:0] brd,
                                input logic es, er, input logic [31:0] erd, ea);
        vec_t t;
        t.r = r; t.v = v; t.rd = rd_; t.wr = wr_; t.a = a; t.aok = aok; t.dok = dok;
        t.brd = brd; t.e_stall = es; t.e_req = er; t.e_rdata = erd; t.e_addr = ea;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, rd_, wr_, input logic [31:0] a,
                         input logic aok, dok, input logic [31:0] brd);
        valid = v; rd = rd_; wr = wr_; addr = a;
        bus_addr_ok = aok; bus_data_ok = dok; bus_rdata = brd;
        #1;
    endtask

    localparam logic [31:0] A = 32'h1FAF_F000;
    localparam logic [31:0] B = 32'h1FD0_0010;
    localparam logic [31:0] C = 32'h1FE0_0000;
    localparam logic [31:0] S = 32'h1FAF_F004;
    localparam logic [31:0] L = 32'h1FAF_F008;

    initial begin
        rst = 1'b1; valid = 0; rd = 0; wr = 0; addr = 0; wstrb = 0; wdata = 0; size = 2'd2;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //                 r  v  rd wr addr aok dok brd           stall req rdata         bus_addr
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 1, 1, 0, A, 1, 1, 32'hDEADBEEF,       1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 1, 1, 0, A, 1, 1, 32'hDEADBEEF,       1, 1, 32'h0,        A));
        tbl.push_back(mk(0, 1, 1, 0, A, 1, 1, 32'hDEADBEEF,       1, 0, 32'h0,        A));
        tbl.push_back(mk(0, 1, 1, 0, A, 1, 1, 32'hDEADBEEF,       0, 0, 32'hDEADBEEF, A));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h12345678,       0, 0, 32'hDEADBEEF, A));
        tbl.push_back(mk(0, 1, 1, 0, B, 0, 0, 0,                  1, 0, 32'hDEADBEEF, A));
        tbl.push_back(mk(0, 1, 1, 0, B, 0, 0, 0,                  1, 1, 32'hDEADBEEF, B));
        tbl.push_back(mk(0, 1, 1, 0, B, 0, 0, 0,                  1, 1, 32'hDEADBEEF, B));
        tbl.push_back(mk(0, 1, 1, 0, B, 0, 0, 0,                  1, 1, 32'hDEADBEEF, B));
        tbl.push_back(mk(0, 1, 1, 0, B, 0, 0, 0,                  1, 1, 32'hDEADBEEF, B));
        tbl.push_back(mk(0, 1, 1, 0, B, 1, 0, 0,                  1, 1, 32'hDEADBEEF, B));
        tbl.push_back(mk(0, 1, 1, 0, B, 0, 0, 0,                  1, 0, 32'hDEADBEEF, B));
        tbl.push_back(mk(0, 1, 1, 0, B, 0, 1, 32'hCAFEF00D,       1, 0, 32'hDEADBEEF, B));
        tbl.push_back(mk(0, 1, 1, 0, B, 0, 0, 0,                  0, 0, 32'hCAFEF00D, B));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 32'hCAFEF00D, B));
        tbl.push_back(mk(0, 1, 0, 0, C, 1, 0, 0,                  0, 0, 32'hCAFEF00D, B));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 32'hCAFEF00D, B));
        tbl.push_back(mk(0, 1, 1, 0, C, 1, 0, 0,                  1, 0, 32'hCAFEF00D, B));
        tbl.push_back(mk(0, 1, 1, 0, C, 1, 0, 0,                  1, 1, 32'hCAFEF00D, C));
        tbl.push_back(mk(0, 1, 1, 0, C, 0, 0, 0,                  1, 0, 32'hCAFEF00D, C));
        tbl.push_back(mk(1, 1, 1, 0, C, 0, 0, 0,                  0, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0,       0, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 32'h0,        32'h0));

        foreach (tbl[i]) begin
            rst = tbl[i].r;
            drive(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].aok, tbl[i].dok, tbl[i].brd);
            chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
            chk($sformatf("row%0d bus_req", i), {31'd0, bus_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("row%0d rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("row%0d bus_addr", i), bus_addr, tbl[i].e_addr);
            @(negedge clk);
        end

        // Byte store: stalls like a load unless posted into the write buffer.
        wdata = 32'h0000_00A5; wstrb = 4'b0001; size = 2'd0;
        drive(1, 0, 1, S, 1, 1, 32'hFFFF_FFFF);
        chk("st issue stall", {31'd0, stall}, {31'd0, ~WBUF});
        @(negedge clk);
        drive(~WBUF, 0, ~WBUF, S, 1, 1, 32'hFFFF_FFFF);
        chk("st req bus_req", {31'd0, bus_req}, 32'd1);
        chk("st req bus_wr", {31'd0, bus_wr}, 32'd1);
        chk("st req bus_wstrb", {28'd0, bus_wstrb}, 32'd1);
        chk("st req bus_wdata", bus_wdata, 32'h0000_00A5);
        chk("st req bus_size", {30'd0, bus_size}, 32'd0);
        chk("st req bus_addr", bus_addr, S);
        chk("st req stall", {31'd0, stall}, {31'd0, ~WBUF});
        @(negedge clk);
        drive(~WBUF, 0, ~WBUF, S, 1, 1, 32'hFFFF_FFFF);
        chk("st wait stall", {31'd0, stall}, {31'd0, ~WBUF});
        chk("st wait bus_req", {31'd0, bus_req}, 32'd0);
        @(negedge clk);
        drive(~WBUF, 0, ~WBUF, S, 0, 0, 0);
        chk("st done stall", {31'd0, stall}, 32'd0);
        chk("st done rdata", rdata, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("st idle bus_req", {31'd0, bus_req}, 32'd0);
        @(negedge clk);

`ifdef UNCACHE_WBUF_EN
        // Posted store followed by a load: the load waits for the drain.
        drive(1, 0, 1, S, 1, 1, 0);
        chk("wb post stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        wdata = 0; wstrb = 0; size = 2'd2;
        drive(1, 1, 0, L, 1, 1, 32'h1111_1111);
        chk("wb drain req", {31'd0, bus_req}, 32'd1);
        chk("wb drain wr", {31'd0, bus_wr}, 32'd1);
        chk("wb drain addr", bus_addr, S);
        chk("wb ld stall1", {31'd0, stall}, 32'd1);
        @(negedge clk);
        drive(1, 1, 0, L, 1, 1, 32'h2222_2222);
        chk("wb ld stall2", {31'd0, stall}, 32'd1);
        @(negedge clk);
        drive(1, 1, 0, L, 1, 1, 0);
        chk("wb drain done stall", {31'd0, stall}, 32'd1);
        chk("wb drain rdata", rdata, 32'h0);
        @(negedge clk);
        drive(1, 1, 0, L, 1, 1, 0);
        chk("wb ld idle stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        drive(1, 1, 0, L, 1, 1, 0);
        chk("wb ld req", {31'd0, bus_req}, 32'd1);
        chk("wb ld wr", {31'd0, bus_wr}, 32'd0);
        chk("wb ld addr", bus_addr, L);
        @(negedge clk);
        drive(1, 1, 0, L, 1, 1, 32'h55AA_55AA);
        chk("wb ld wait stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        drive(1, 1, 0, L, 0, 0, 0);
        chk("wb ld done stall", {31'd0, stall}, 32'd0);
        chk("wb ld done rdata", rdata, 32'h55AA_55AA);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
